arbiter: RTL and testbench



---
 rtl/arbiter.sv | 112 +++++++++++
 tb/tb_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/arbiter.sv
// Four-requester round-robin arbiter with ack handshake and one-hot registered grant.
// Define ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ack,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] w_winner;

`ifdef ARBITER_FIXED_PRIO_EN
  // Scan downward so the lowest set index is written last and wins.
  always_comb begin
    w_winner = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[i-1]) begin
        w_winner      = '0;
        w_winner[i-1] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_gidx;
  logic             w_release;

  // Scan offsets from farthest to nearest so the first requester after r_last wins.
  always_comb begin
    w_winner = '0;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      if (req[(32'(r_last) + off) % NUM_REQ]) begin
        w_winner = '0;
        w_winner[(32'(r_last) + off) % NUM_REQ] = 1'b1;
      end
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_gidx = IDX_W'(i);
    end
  end

  assign w_release = (r_state == BUSY) && ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last <= IDX_W'(NUM_REQ - 1);
    end else if (w_release) begin
      r_last <= w_gidx;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        if (|req) begin
          w_grant_nxt = w_winner;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ack) begin
          w_grant_nxt = '0;
          w_state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        w_grant_nxt = '0;
        if (!ack) w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_arbiter.sv
// Directed self-checking bench for the arbiter; expected grants are hand-computed.
module tb_arbiter;

  logic       clock;
  logic       reset;
  logic       ack;
  logic [3:0] req;
  logic [3:0] grant;

  int unsigned n_checks;
  int unsigned n_pass;

  arbiter #(.NUM_REQ(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .ack   (ack),
    .req   (req),
    .grant (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    ack      = 1'b0;
    req      = 4'b1111;
`ifdef ARBITER_FIXED_PRIO_EN
    rot_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    // Held in reset with requests and toggling ack
    #1;
    check("reset_t0", grant, 4'b0000);
    for (int unsigned i = 0; i < 4; i++) begin
      ack = ~ack;
      tick();
      check("reset_hold", grant, 4'b0000);
    end

    // First grant and no preemption on req change
    reset = 1'b1;
    ack   = 1'b0;
    req   = 4'b1010;
    tick();
    check("first_grant", grant, 4'b0010);
    req = 4'b1000;
    tick();
    check("hold_req_chg", grant, 4'b0010);
    tick();
    check("hold_req_chg2", grant, 4'b0010);

    // Asynchronous reset mid-BUSY
    #2 reset = 1'b0;
    #1;
    check("async_reset", grant, 4'b0000);
    tick();
    check("async_reset_edge", grant, 4'b0000);
    reset = 1'b1;

    // Round-robin rotation with single-cycle ack pulses
    req = 4'b1111;
    for (int unsigned g = 0; g < 5; g++) begin
      tick();
      check("rot_grant", grant, rot_exp[g]);
      ack = 1'b1;
      tick();
      check("rot_gap1", grant, 4'b0000);
      ack = 1'b0;
      tick();
      check("rot_gap2", grant, 4'b0000);
    end

    // Long ack: restart from reset so requester 0 is served first
    req   = 4'b0000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req   = 4'b0011;
    tick();
    check("long_first", grant, 4'b0001);
    ack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("long_ack_hi", grant, 4'b0000);
    end
    ack = 1'b0;
    tick();
    check("long_ack_lo", grant, 4'b0000);
    tick();
`ifdef ARBITER_FIXED_PRIO_EN
    check("long_next", grant, 4'b0001);
`else
    check("long_next", grant, 4'b0010);
`endif
    ack = 1'b1;
    tick();
    check("long_rel", grant, 4'b0000);
    ack = 1'b0;
    tick();

    // Serve requester 2, then check wrap-around skipping requester 3
    req = 4'b0100;
    tick();
    check("serve2", grant, 4'b0100);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("serve2_gap", grant, 4'b0000);
    req = 4'b0101;
    tick();
    check("wrap_skip", grant, 4'b0001);

    // Release, then ack already high when the next grant issues
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    req = 4'b0010;
    tick();
    check("ack_pre_grant", grant, 4'b0010);
    tick();
    check("ack_pre_one_cycle", grant, 4'b0000);
    ack = 1'b0;
    req = 4'b0000;
    tick();
    tick();
    check("idle_no_req", grant, 4'b0000);
    tick();
    check("idle_no_req2", grant, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
